// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - state encoding, default timing and sizing helpers for pll_lock_seq
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } pll_state_e;

  // Defaults assume a 12 MHz reference clock.
  localparam int unsigned DEF_HOLD_CYCLES   = 12;     // 1 us
  localparam int unsigned DEF_LOCK_TIMEOUT  = 12000;  // 1 ms
  localparam int unsigned DEF_STABLE_CYCLES = 1200;   // 100 us
  localparam int unsigned DEF_MAX_RETRIES   = 3;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for a single asynchronous bit
// Ports:
//   clock  - destination clock
//   resetb - asynchronous active-low reset, clears both flops to 0
//   d      - asynchronous input
//   q      - synchronized output, two clock edges behind d
module sync2 (
  input  logic clock,
  input  logic resetb,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic meta_d;
  logic sync_q;
  logic sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_seq.sv
// rtl/pll_lock_seq.sv - PLL reset/lock sequencer with retry, fault and downstream reset release
// Ports:
//   clock      - PLL reference clock, the only clock in this block
//   resetb     - asynchronous active-low reset
//   locked     - PLL LOCK output, asynchronous to clock
//   restart    - synchronous request to re-run the sequence from RESET_PLL
//   pll_resetb - drives PLL RESETB, 0 holds the PLL in reset
//   sys_rst_n  - active-low reset for downstream logic, 1 only while running
//   ready      - high only in RUN
//   fault      - high only in FAULT
//   retries    - failed attempts in the current episode, saturating at 3
module pll_lock_seq
  import pll_seq_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic       locked,
  input  logic       restart,
  output logic       pll_resetb,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [1:0] retries
);

  localparam int unsigned CNT_W = cnt_width(max3(HOLD_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT      = {CNT_W{1'b1}};

  // retries is only two bits wide, so a larger limit behaves as 3.
  localparam logic [1:0] RETRY_LIMIT = (MAX_RETRIES > 3) ? 2'd3 : 2'(MAX_RETRIES);

  logic locked_s;

  pll_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retries_q, retries_d;
  logic             pll_resetb_q, pll_resetb_d;
  logic             sys_rst_n_q, sys_rst_n_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;
  logic             attempt_failed;

  sync2 u_lock_sync (
    .clock  (clock),
    .resetb (resetb),
    .d      (locked),
    .q      (locked_s)
  );

  always_comb begin
    state_d        = state_q;
    retries_d      = retries_q;
    attempt_failed = 1'b0;

    if (restart) begin
      state_d   = ST_RESET_PLL;
      retries_d = 2'd0;
    end else begin
      case (state_q)
        ST_RESET_PLL: begin
          if (cnt_q == HOLD_LAST) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (locked_s)                   state_d = ST_STABLE;
          else if (cnt_q == TIMEOUT_LAST) attempt_failed = 1'b1;
        end
        ST_STABLE: begin
          // Lock dropping out is checked before the release count so a drop on the
          // last stable cycle still counts as a failed attempt.
          if (!locked_s) begin
            attempt_failed = 1'b1;
          end else if (cnt_q == STABLE_LAST) begin
            state_d   = ST_RUN;
            retries_d = 2'd0;
          end
        end
        ST_RUN: begin
          // Losing lock after a good release starts a fresh episode, not a retry.
          if (!locked_s) begin
            state_d   = ST_RESET_PLL;
            retries_d = 2'd0;
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d   = ST_RESET_PLL;
          retries_d = 2'd0;
        end
      endcase

      if (attempt_failed) begin
        if (retries_q >= RETRY_LIMIT) begin
          state_d = ST_FAULT;
        end else begin
          state_d = ST_RESET_PLL;
          if (retries_q != 2'd3) retries_d = retries_q + 2'd1;
        end
      end
    end
  end

  // One shared counter; a restart also clears it so RESET_PLL always gets a full hold.
  always_comb begin
    cnt_d = cnt_q;
    if (restart || (state_d != state_q)) cnt_d = '0;
    else if (cnt_q != CNT_SAT)           cnt_d = cnt_q + 1'b1;
  end

  // Outputs are decoded from the next state so they move on the same edge as the state.
  always_comb begin
    pll_resetb_d = !((state_d == ST_RESET_PLL) || (state_d == ST_FAULT));
    sys_rst_n_d  = (state_d == ST_RUN);
    ready_d      = (state_d == ST_RUN);
    fault_d      = (state_d == ST_FAULT);
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q      <= ST_RESET_PLL;
      cnt_q        <= '0;
      retries_q    <= 2'd0;
      pll_resetb_q <= 1'b0;
      sys_rst_n_q  <= 1'b0;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retries_q    <= retries_d;
      pll_resetb_q <= pll_resetb_d;
      sys_rst_n_q  <= sys_rst_n_d;
      ready_q      <= ready_d;
      fault_q      <= fault_d;
    end
  end

  assign pll_resetb = pll_resetb_q;
  assign sys_rst_n  = sys_rst_n_q;
  assign ready      = ready_q;
  assign fault      = fault_q;
  assign retries    = retries_q;

endmodule

// File: tb/tb_pll_lock_seq.sv
// tb/tb_pll_lock_seq.sv - directed self-checking bench for pll_lock_seq
module tb_pll_lock_seq;

  logic       clock;
  logic       resetb;
  logic       locked;
  logic       restart;
  logic       pll_resetb;
  logic       sys_rst_n;
  logic       ready;
  logic       fault;
  logic [1:0] retries;

  int errors = 0;
  int checks = 0;

  pll_lock_seq #(
    .HOLD_CYCLES   (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2)
  ) dut (
    .clock      (clock),
    .resetb     (resetb),
    .locked     (locked),
    .restart    (restart),
    .pll_resetb (pll_resetb),
    .sys_rst_n  (sys_rst_n),
    .ready      (ready),
    .fault      (fault),
    .retries    (retries)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // sel: 0 = pll_resetb, 1 = ready, 2 = fault. n is the number of edges taken (capped at bound).
  task automatic wait_until(input int sel, input logic val, input int bound, output int n);
    logic cur;
    n = 0;
    do begin
      tick(1);
      n++;
      cur = (sel == 0) ? pll_resetb : (sel == 1) ? ready : fault;
    end while (cur !== val && n < bound);
  endtask

  task automatic test_reset;
    resetb = 1'b1; locked = 1'b0; restart = 1'b0;
    #1 resetb = 1'b0;
    #2;
    checks++; if ({pll_resetb, sys_rst_n, ready, fault} !== 4'b0000) begin errors++;
      $display("FAIL reset_outs: got %b expected 0000", {pll_resetb, sys_rst_n, ready, fault}); end
    checks++; if (retries !== 2'd0) begin errors++; $display("FAIL reset_retries: got %0d expected 0", retries); end
    tick(2);
    checks++; if ({pll_resetb, sys_rst_n, ready, fault} !== 4'b0000) begin errors++;
      $display("FAIL reset_held: got %b expected 0000", {pll_resetb, sys_rst_n, ready, fault}); end
  endtask

  task automatic test_nominal;
    int n;
    resetb = 1'b1;
    wait_until(0, 1'b1, 30, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL nom_hold: got %0d expected 4", n); end
    tick(3);
    locked = 1'b1;
    wait_until(1, 1'b1, 40, n);
    checks++; if (n !== 11) begin errors++; $display("FAIL nom_latency: got %0d expected 11", n); end
    checks++; if ({sys_rst_n, pll_resetb, fault} !== 3'b110) begin errors++;
      $display("FAIL nom_outs: got %b expected 110", {sys_rst_n, pll_resetb, fault}); end
    checks++; if (retries !== 2'd0) begin errors++; $display("FAIL nom_retries: got %0d expected 0", retries); end
  endtask

  task automatic test_loss_in_run;
    int n;
    locked = 1'b0;
    tick(2);
    checks++; if (sys_rst_n !== 1'b1) begin errors++; $display("FAIL loss_early: got %b expected 1", sys_rst_n); end
    tick(1);
    checks++; if ({sys_rst_n, ready, pll_resetb} !== 3'b000) begin errors++;
      $display("FAIL loss_outs: got %b expected 000", {sys_rst_n, ready, pll_resetb}); end
    checks++; if (retries !== 2'd0) begin errors++; $display("FAIL loss_retries: got %0d expected 0", retries); end
    wait_until(0, 1'b1, 30, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL loss_hold: got %0d expected 4", n); end
    locked = 1'b1;
    wait_until(1, 1'b1, 40, n);
    checks++; if (n !== 11) begin errors++; $display("FAIL loss_relock: got %0d expected 11", n); end
  endtask

  task automatic test_glitch_stable;
    int n;
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    checks++; if (pll_resetb !== 1'b0) begin errors++; $display("FAIL glitch_restart: got %b expected 0", pll_resetb); end
    tick(6);
    locked = 1'b0;
    tick(1);
    locked = 1'b1;
    tick(1);
    checks++; if (pll_resetb !== 1'b1) begin errors++; $display("FAIL glitch_still_stable: got %b expected 1", pll_resetb); end
    tick(1);
    checks++; if (pll_resetb !== 1'b0) begin errors++; $display("FAIL glitch_reset_pll: got %b expected 0", pll_resetb); end
    checks++; if (retries !== 2'd1) begin errors++; $display("FAIL glitch_retries: got %0d expected 1", retries); end
    wait_until(1, 1'b1, 40, n);
    checks++; if (n !== 13) begin errors++; $display("FAIL glitch_relock: got %0d expected 13", n); end
    checks++; if (retries !== 2'd0) begin errors++; $display("FAIL glitch_run_retries: got %0d expected 0", retries); end
  endtask

  task automatic test_restart_priority;
    int n;
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    tick(6);
    locked = 1'b0;
    tick(1);
    locked = 1'b1;
    tick(1);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    checks++; if (pll_resetb !== 1'b0) begin errors++; $display("FAIL prio_state: got %b expected 0", pll_resetb); end
    checks++; if (retries !== 2'd0) begin errors++; $display("FAIL prio_retries: got %0d expected 0", retries); end
    wait_until(1, 1'b1, 40, n);
    checks++; if (n !== 13) begin errors++; $display("FAIL prio_relock: got %0d expected 13", n); end
  endtask

  task automatic test_timeout_fault;
    int n;
    locked  = 1'b0;
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_until(0, 1'b1, 30, n);
      checks++; if (n !== 4) begin errors++; $display("FAIL to_hold%0d: got %0d expected 4", i, n); end
      checks++; if (retries !== 2'(i)) begin errors++; $display("FAIL to_retries%0d: got %0d expected %0d", i, retries, i); end
      if (i < 2) begin
        wait_until(0, 1'b0, 40, n);
        checks++; if (n !== 20) begin errors++; $display("FAIL to_wait%0d: got %0d expected 20", i, n); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL to_nofault%0d: got %b expected 0", i, fault); end
      end else begin
        wait_until(2, 1'b1, 40, n);
        checks++; if (n !== 20) begin errors++; $display("FAIL to_fault_wait: got %0d expected 20", n); end
        checks++; if ({fault, pll_resetb, retries} !== 4'b1010) begin errors++;
          $display("FAIL to_fault_outs: got %b expected 1010", {fault, pll_resetb, retries}); end
      end
    end
    tick(120);
    checks++; if ({fault, pll_resetb, ready, sys_rst_n} !== 4'b1000) begin errors++;
      $display("FAIL fault_terminal: got %b expected 1000", {fault, pll_resetb, ready, sys_rst_n}); end
  endtask

  task automatic test_restart_fault;
    int n;
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    checks++; if ({fault, pll_resetb, retries} !== 4'b0000) begin errors++;
      $display("FAIL rf_outs: got %b expected 0000", {fault, pll_resetb, retries}); end
    wait_until(0, 1'b1, 30, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL rf_hold: got %0d expected 4", n); end
    locked = 1'b1;
    wait_until(1, 1'b1, 40, n);
    checks++; if (n !== 11) begin errors++; $display("FAIL rf_relock: got %0d expected 11", n); end
  endtask

  task automatic test_async_reset;
    int n;
    #2 resetb = 1'b0;
    #1;
    checks++; if ({pll_resetb, sys_rst_n, ready, fault, retries} !== 6'b000000) begin errors++;
      $display("FAIL ar_outs: got %b expected 000000", {pll_resetb, sys_rst_n, ready, fault, retries}); end
    tick(1);
    resetb = 1'b1;
    wait_until(0, 1'b1, 30, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL ar_hold: got %0d expected 4", n); end
    wait_until(1, 1'b1, 40, n);
    checks++; if (n !== 9) begin errors++; $display("FAIL ar_relock: got %0d expected 9", n); end
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_loss_in_run;
    test_glitch_stable;
    test_restart_priority;
    test_timeout_fault;
    test_restart_fault;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
